demux_bank_param: RTL

- Parameterized registered demultiplexer / write-side register bank: routes one WORD-wide input into one of 2**SEL storage slots.
- All slots are presented as one packed bus, in the same slot ordering the team's parameterized read mux consumes.
- Slot i occupies bits [WORD*i+WORD-1 : WORD*i].
- Supports single addressed writes and an auto-incrementing burst fill; per-slot valid flags.

---
 rtl/demux_bank_param.sv | 133 +++++++++++++
 1 files changed

// File: rtl/demux_bank_param.sv
// Registered demultiplexer / write-side register bank with single writes and an auto-incrementing
// burst fill. Optional overwrite protection is enabled by defining DEMUX_BANK_OVWR_PROTECT_EN.
module demux_bank_param #(
    parameter int unsigned SEL  = 2,
    parameter int unsigned WORD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORD-1:0]            DATAin,
    input  logic [SEL-1:0]             Select,
    input  logic                       WrEn,
    input  logic                       Start,
    input  logic                       Clear,
    output logic [(2**SEL)*WORD-1:0]   DATAout,
    output logic [2**SEL-1:0]          Valid,
    output logic                       Busy,
    output logic                       Full,
    output logic                       Err
);

    localparam int unsigned NSlot = 2 ** SEL;
    localparam logic [SEL:0] CntLast = {1'b0, {SEL{1'b1}}};

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL-1:0]          ptr_q, ptr_d;
    logic [SEL:0]            cnt_q, cnt_d;
    logic [NSlot*WORD-1:0]   data_q, data_d;
    logic [NSlot-1:0]        valid_q, valid_d;

    logic                    wr_req;
    logic                    wr_blocked;
    logic [SEL-1:0]          wr_tgt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_req  = 1'b0;
        wr_tgt  = Select;

        if (Clear) begin
            state_d = StIdle;
            ptr_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        state_d = StBurst;
                        ptr_d   = Select;
                        cnt_d   = '0;
                    end else if (WrEn) begin
                        wr_req = 1'b1;
                        wr_tgt = Select;
                    end
                end
                StBurst: begin
                    if (WrEn) begin
                        wr_req = 1'b1;
                        wr_tgt = ptr_q;
                        // Pointer wraps naturally at SEL bits; a dropped write still advances it.
                        ptr_d  = ptr_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CntLast) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef DEMUX_BANK_OVWR_PROTECT_EN
    assign wr_blocked = valid_q[wr_tgt];
`else
    assign wr_blocked = 1'b0;
`endif

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (Clear) begin
            valid_d = '0;
        end else if (wr_req && !wr_blocked) begin
            data_d[int'(wr_tgt)*WORD +: WORD] = DATAin;
            valid_d[wr_tgt]                   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef DEMUX_BANK_OVWR_PROTECT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wr_req && wr_blocked;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign DATAout = data_q;
    assign Valid   = valid_q;
    assign Busy    = (state_q == StBurst);
    assign Full    = &valid_q;

endmodule
